fp_special_detect: RTL and testbench

FP_SPECIAL_DETECT -- requirements
Module: fp_special_detect

---
 rtl/fp_pkg.sv | 20 ++
 rtl/fp_classify.sv | 22 ++
 rtl/fp_special_detect.sv | 154 +++++++++++++++
 tb/tb_fp_special_detect.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared single-precision field widths, quiet-NaN constant and result-select codes
// used by the special-case detector and the downstream result selector.
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    FLAG_NONE          = 3'b000,
    FLAG_NAN           = 3'b001,
    FLAG_COPY_A        = 3'b010,
    FLAG_COPY_B        = 3'b011,
    FLAG_FIN_MIN_INF   = 3'b100,
    FLAG_ZERO_MIN_ZERO = 3'b101,
    FLAG_ZERO_MIN_SOME = 3'b110,
    FLAG_SUB_SAME_VAL  = 3'b111
  } exc_flag_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier working on the magnitude (exponent + mantissa).
// Denormals fall through as finite nonzero.
module fp_classify
  import fp_pkg::*;
(
  input  logic [EXP_W+MANT_W-1:0] magnitude_i,
  output logic                    isNan_o,
  output logic                    isInf_o,
  output logic                    isZero_o
);

  logic [EXP_W-1:0]  expField;
  logic [MANT_W-1:0] mantField;

  assign expField  = magnitude_i[EXP_W+MANT_W-1:MANT_W];
  assign mantField = magnitude_i[MANT_W-1:0];

  assign isNan_o  = (&expField) && (|mantField);
  assign isInf_o  = (&expField) && !(|mantField);
  assign isZero_o = !(|expField) && !(|mantField);

endmodule

// File: rtl/fp_special_detect.sv
// Two-stage special-operand detector for FP add/sub: S1 captures operands, S2 holds
// the result-select code plus operand passthrough for the normal-path adder.
module fp_special_detect
  import fp_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             op_out,
  output logic [2:0]       exception_flag,
  output logic             sign_a,
  output logic             sign_b,
  output logic [WIDTH-2:0] copied_operand,
  output logic [15:0]      special_count
);

  logic             s1Valid_q;
  logic [WIDTH-1:0] s1A_q, s1B_q;
  logic             s1Op_q;

  logic             s2Valid_q;
  exc_flag_e        flag_q, flag_d;
  logic [WIDTH-2:0] copied_q, copied_d;
  logic             signA_q, signB_q;
  logic [WIDTH-1:0] aOut_q, bOut_q;
  logic             opOut_q;
  logic [15:0]      count_q;

  logic             s1Advance, accept, outFire;
  logic             aNan, aInf, aZero, bNan, bInf, bZero;
  logic [WIDTH-2:0] magA, magB;

  assign outFire   = s2Valid_q && out_ready;
  assign s1Advance = s1Valid_q && (!s2Valid_q || out_ready);
  assign in_ready  = !s1Valid_q || s1Advance;
  assign accept    = in_valid && in_ready;

  assign magA = s1A_q[WIDTH-2:0];
  assign magB = s1B_q[WIDTH-2:0];

  fp_classify uClassA (.magnitude_i(magA), .isNan_o(aNan), .isInf_o(aInf), .isZero_o(aZero));
  fp_classify uClassB (.magnitude_i(magB), .isNan_o(bNan), .isInf_o(bInf), .isZero_o(bZero));

  // First-match priority; infinities of opposite effective sign cancel to NaN.
  always_comb begin
    flag_d   = FLAG_NONE;
    copied_d = '0;
    if (aNan || bNan) begin
      flag_d = FLAG_NAN;
    end else if (aInf && bInf) begin
      if ((s1A_q[WIDTH-1] ^ s1B_q[WIDTH-1]) == s1Op_q) begin
        flag_d   = FLAG_COPY_A;
        copied_d = magA;
      end else begin
        flag_d = FLAG_NAN;
      end
    end else if (aInf) begin
      flag_d   = FLAG_COPY_A;
      copied_d = magA;
    end else if (bInf) begin
      if (s1Op_q) begin
        flag_d = FLAG_FIN_MIN_INF;
      end else begin
        flag_d   = FLAG_COPY_B;
        copied_d = magB;
      end
    end else if (aZero && bZero) begin
      flag_d = s1Op_q ? FLAG_COPY_A : FLAG_ZERO_MIN_ZERO;
    end else if (bZero) begin
      flag_d   = FLAG_COPY_A;
      copied_d = magA;
    end else if (aZero) begin
      flag_d   = s1Op_q ? FLAG_ZERO_MIN_SOME : FLAG_COPY_B;
      copied_d = magB;
    end else if (s1Op_q && (s1A_q == s1B_q)) begin
      flag_d = FLAG_SUB_SAME_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      s1A_q     <= '0;
      s1B_q     <= '0;
      s1Op_q    <= 1'b0;
    end else begin
      if (flush)          s1Valid_q <= 1'b0;
      else if (accept)    s1Valid_q <= 1'b1;
      else if (s1Advance) s1Valid_q <= 1'b0;
      if (accept && !flush) begin
        s1A_q  <= a;
        s1B_q  <= b;
        s1Op_q <= op;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2Valid_q <= 1'b0;
      flag_q    <= FLAG_NONE;
      copied_q  <= '0;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      aOut_q    <= '0;
      bOut_q    <= '0;
      opOut_q   <= 1'b0;
    end else begin
      if (flush)          s2Valid_q <= 1'b0;
      else if (s1Advance) s2Valid_q <= 1'b1;
      else if (outFire)   s2Valid_q <= 1'b0;
      if (s1Advance && !flush) begin
        flag_q   <= flag_d;
        copied_q <= copied_d;
        signA_q  <= s1A_q[WIDTH-1];
        signB_q  <= s1B_q[WIDTH-1];
        aOut_q   <= s1A_q;
        bOut_q   <= s1B_q;
        opOut_q  <= s1Op_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (outFire && !flush && (flag_q != FLAG_NONE) && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign out_valid      = s2Valid_q;
  assign exception_flag = flag_q;
  assign copied_operand = copied_q;
  assign sign_a         = signA_q;
  assign sign_b         = signB_q;
  assign a_out          = aOut_q;
  assign b_out          = bOut_q;
  assign op_out         = opOut_q;
  assign special_count  = count_q;

endmodule

// File: tb/tb_fp_special_detect.sv
// Directed bench for fp_special_detect: an independent reference model fills a
// scoreboard at input acceptance, and a monitor compares each delivered result.
module tb_fp_special_detect;

  logic        clk, rst, flush, in_valid, in_ready, op, out_valid, out_ready;
  logic [31:0] a, b, a_out, b_out;
  logic        op_out, sign_a, sign_b;
  logic [2:0]  exception_flag;
  logic [30:0] copied_operand;
  logic [15:0] special_count;

  typedef struct {
    logic [2:0]  flag;
    logic [30:0] copied;
    logic        sa, sb;
    logic [31:0] a, b;
    logic        op;
  } expT;

  expT         sbQueue[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] modelCount = 16'd0;
  logic [31:0] heldA;

  fp_special_detect #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .b_out(b_out), .op_out(op_out), .exception_flag(exception_flag),
    .sign_a(sign_a), .sign_b(sign_b), .copied_operand(copied_operand),
    .special_count(special_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic expT model(input logic [31:0] x, input logic [31:0] y, input logic sub);
    expT e;
    logic xNan, xInf, xZero, yNan, yInf, yZero;
    xNan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    xInf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    xZero = (x[30:0] == 31'd0);
    yNan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    yInf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    yZero = (y[30:0] == 31'd0);
    e.flag = 3'b000; e.copied = 31'd0;
    e.sa = x[31]; e.sb = y[31]; e.a = x; e.b = y; e.op = sub;
    if (xNan || yNan) e.flag = 3'b001;
    else if (xInf && yInf) begin
      if ((!sub && x[31] == y[31]) || (sub && x[31] != y[31])) begin
        e.flag = 3'b010; e.copied = x[30:0];
      end else e.flag = 3'b001;
    end
    else if (xInf) begin e.flag = 3'b010; e.copied = x[30:0]; end
    else if (yInf) begin
      if (sub) e.flag = 3'b100;
      else begin e.flag = 3'b011; e.copied = y[30:0]; end
    end
    else if (xZero && yZero) e.flag = sub ? 3'b010 : 3'b101;
    else if (yZero) begin e.flag = 3'b010; e.copied = x[30:0]; end
    else if (xZero) begin e.flag = sub ? 3'b110 : 3'b011; e.copied = y[30:0]; end
    else if (sub && x == y) e.flag = 3'b111;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitAccept();
    bit accepted = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin accepted = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!accepted) checkOutput("accept_timeout", 32'd0, 32'd1);
    else begin @(posedge clk); #1; end
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic sub);
    a = x; b = y; op = sub; in_valid = 1'b1;
    waitAccept();
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (sbQueue.size() == 0) break;
    end
    checkOutput("drain_left", sbQueue.size(), 32'd0);
  endtask

  // Scoreboard monitor: compare delivered results, then record newly accepted inputs.
  always @(negedge clk) begin
    expT e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sbQueue.size() == 0) checkOutput("unexpected_output", 32'd1, 32'd0);
        else begin
          e = sbQueue.pop_front();
          checkOutput("flag", {29'd0, exception_flag}, {29'd0, e.flag});
          checkOutput("copied", {1'b0, copied_operand}, {1'b0, e.copied});
          checkOutput("sign_a", {31'd0, sign_a}, {31'd0, e.sa});
          checkOutput("sign_b", {31'd0, sign_b}, {31'd0, e.sb});
          checkOutput("a_out", a_out, e.a);
          checkOutput("b_out", b_out, e.b);
          checkOutput("op_out", {31'd0, op_out}, {31'd0, e.op});
          if (e.flag != 3'b000 && modelCount != 16'hFFFF) modelCount++;
        end
      end
      if (flush) sbQueue.delete();
      else if (in_valid && in_ready) sbQueue.push_back(model(a, b, op));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 1'b0;
    #2;
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_flag", {29'd0, exception_flag}, 32'd0);
    checkOutput("rst_count", {16'd0, special_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // NaN operand: latency and counter.
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0);
    checkOutput("latency_early", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("latency_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("nan_flag", {29'd0, exception_flag}, 32'd1);
    waitDrain();
    checkOutput("count_after_nan", {16'd0, special_count}, 32'd1);

    // Back-to-back special and normal cases at full throughput.
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b0);
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b1);
    applyStimulus(32'h40400000, 32'h7F800000, 1'b1);
    applyStimulus(32'h00000000, 32'hC0000000, 1'b1);
    applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b1);
    applyStimulus(32'h3F800000, 32'h40000000, 1'b0);
    applyStimulus(32'h80000000, 32'h00000000, 1'b0);
    applyStimulus(32'h00000000, 32'h80000000, 1'b1);
    applyStimulus(32'h00000001, 32'h00000000, 1'b1);
    applyStimulus(32'hFF800000, 32'h3F800000, 1'b1);
    applyStimulus(32'h3F800000, 32'hFF800000, 1'b0);
    applyStimulus(32'h00000000, 32'h3F800000, 1'b0);
    applyStimulus(32'h3F800000, 32'hFFC00001, 1'b1);
    applyStimulus(32'h3F800000, 32'h3F800001, 1'b1);
    waitDrain();
    checkOutput("count_group", {16'd0, special_count}, {16'd0, modelCount});

    // Backpressure: two accepts fill the pipe, third waits, order preserved.
    out_ready = 1'b0;
    applyStimulus(32'h7FC00000, 32'h00000000, 1'b0);
    applyStimulus(32'h40400000, 32'h7F800000, 1'b1);
    a = 32'h3F800000; b = 32'h40000000; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    checkOutput("stall_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("stall_out_valid", {31'd0, out_valid}, 32'd1);
    heldA = a_out;
    repeat (2) @(negedge clk);
    checkOutput("stall_hold", a_out, heldA);
    @(posedge clk); #1;
    out_ready = 1'b1;
    waitAccept();
    waitDrain();
    checkOutput("count_backpressure", {16'd0, special_count}, {16'd0, modelCount});

    // Flush with both stages full; same-cycle input is dropped.
    out_ready = 1'b0;
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0);
    applyStimulus(32'h3FC00000, 32'h3FC00000, 1'b1);
    flush = 1'b1; a = 32'h7F800000; b = 32'h00000000; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("flush_count", {16'd0, special_count}, {16'd0, modelCount});
    out_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    checkOutput("flush_no_output", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0);
    applyStimulus(32'h7F800000, 32'hFF800000, 1'b1);
    @(negedge clk);
    checkOutput("pre_rst_flag", {29'd0, exception_flag}, 32'd1);
    #2 rst = 1'b1;
    sbQueue.delete();
    modelCount = 16'd0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("midrst_flag", {29'd0, exception_flag}, 32'd0);
    checkOutput("midrst_copied", {1'b0, copied_operand}, 32'd0);
    checkOutput("midrst_a_out", a_out, 32'd0);
    checkOutput("midrst_b_out", b_out, 32'd0);
    checkOutput("midrst_signs", {30'd0, sign_a, sign_b}, 32'd0);
    checkOutput("midrst_count", {16'd0, special_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'h00000000, 32'hC0000000, 1'b1);
    waitDrain();
    checkOutput("post_rst_count", {16'd0, special_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
